// File: rtl/fp_arith_pkg.sv
// Shared arithmetic package: FSM state encoding and iteration-counter sizing
// used by mult_shift_add.
package fp_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_COUNT_W = $clog2(DEFAULT_WIDTH);

  // Counter width for a given operand width: $clog2(width), never below one bit.
  function automatic int count_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mult_shift_add_if.sv
// Operand/product handshake bundle for mult_shift_add.
// Handshake rules: a transfer happens on a rising clk edge where valid and
// ready are both high; the source holds its payload stable while valid is
// high and ready is low, and ready never depends combinationally on valid.
interface mult_shift_add_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/adder_nbit.sv
// N-bit adder with carry-in. IMPL_TYPE selects the structure:
// 1 = explicit ripple-carry chain, anything else = behavioural '+'.
module adder_nbit #(
  parameter int WIDTH     = 64,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  generate
    if (IMPL_TYPE == 1) begin : g_ripple
      logic carry;
      // Bit-serial ripple chain; the final carry-out is not needed.
      always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
          sum[i] = a[i] ^ b[i] ^ carry;
          carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
      end
    end else begin : g_behav
      assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};
    end
  endgenerate

endmodule

// File: rtl/mult_shift_add.sv
// Iterative unsigned shift-and-add multiplier, one multiplier bit per cycle.
// Optional feature: define MULT_SHIFT_ADD_EARLY_EXIT_EN to leave CALC as soon
// as the remaining multiplier bits are all zero.
module mult_shift_add
  import fp_arith_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic              clk,
  input  logic              rst,
  mult_shift_add_if.slave   bus,
  output state_t            dbg_state
);

  localparam int                 COUNT_W    = count_width(WIDTH);
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(WIDTH - 1);

  state_t               state;
  state_t               state_nxt;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mplier;
  logic [COUNT_W-1:0]   count;
  logic                 last_iter;

  // The only adder in the datapath; the product cannot overflow 2*WIDTH bits.
  adder_nbit #(
    .WIDTH     (2*WIDTH),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_adder (
    .a   (acc),
    .b   (mcand),
    .cin (1'b0),
    .sum (acc_sum)
  );

`ifdef MULT_SHIFT_ADD_EARLY_EXIT_EN
  // Stop once the multiplier left after this shift has no set bits.
  assign last_iter = (count == LAST_COUNT) || (mplier[WIDTH-1:1] == '0);
`else
  assign last_iter = (count == LAST_COUNT);
`endif

  assign bus.product = acc;
  assign dbg_state   = state;

  // State register; reset wins over every handshake input.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; unknown encodings fall back to IDLE.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then one shift-and-add step per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
            count  <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + COUNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_shift_add.sv
// Self-checking bench for mult_shift_add: directed cases on an 8-bit instance,
// then randomized back-to-back traffic on 8-bit and 32-bit instances.
// Honours MULT_SHIFT_ADD_EARLY_EXIT_EN in its latency model.
module tb_mult_shift_add;
  import fp_arith_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_shift_add_if #(.WIDTH(8))  bus8();
  mult_shift_add_if #(.WIDTH(32)) bus32();
  state_t dbg8;
  state_t dbg32;

  mult_shift_add #(.WIDTH(8), .IMPL_TYPE(0)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus8.slave),
    .dbg_state (dbg8)
  );

  mult_shift_add #(.WIDTH(32), .IMPL_TYPE(1)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus32.slave),
    .dbg_state (dbg32)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] exp_q8[$];
  logic [63:0] exp_q32[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Cycles from the accept cycle to the first out_valid cycle: one per
  // multiplier bit examined, plus one. With early exit only the bit length of
  // b matters (at least one step).
  function automatic int ref_latency(input int w, input logic [31:0] b);
    int iters;
    iters = w;
`ifdef MULT_SHIFT_ADD_EARLY_EXIT_EN
    iters = 1;
    for (int i = 0; i < w; i++) if (b[i]) iters = i + 1;
`endif
    return iters + 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand pair on the 8-bit DUT and wait for out_valid (out_ready held low).
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b);
    int lat;
    bus8.a = a;
    bus8.b = b;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b0;
    check({tag, " in_ready"}, 64'(bus8.in_ready), 64'd1);
    step();
    bus8.in_valid = 1'b0;
    lat = 1;
    while (!bus8.out_valid && lat < 100) begin
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      step();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(ref_latency(8, 32'(b))));
    check({tag, " product"}, 64'(bus8.product), ref_product(32'(a), 32'(b)));
  endtask

  task automatic release8(input string tag);
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    check({tag, " idle in_ready"}, 64'(bus8.in_ready), 64'd1);
    check({tag, " idle out_valid"}, 64'(bus8.out_valid), 64'd0);
  endtask

  task automatic rand8(input int n_ops);
    int issued = 0;
    int got    = 0;
    int cyc    = 0;
    logic [7:0] ra, rb;
    while (got < n_ops && cyc < 20000) begin
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      if (bus8.in_ready && issued < n_ops) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        if (issued == 0) begin ra = 8'hff; rb = 8'hff; end
        if (issued == 1) ra = 8'h00;
        bus8.a = ra;
        bus8.b = rb;
        bus8.in_valid = 1'b1;
        exp_q8.push_back(16'(ra) * 16'(rb));
        issued++;
      end else begin
        bus8.in_valid = !bus8.in_ready && ($urandom_range(0, 1) == 1);
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
      end
      if (bus8.out_valid && bus8.out_ready) begin
        got++;
        if (exp_q8.size() == 0) check("rand8 spurious", 64'd1, 64'd0);
        else check("rand8 product", 64'(bus8.product), 64'(exp_q8.pop_front()));
      end
      step();
      cyc++;
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    check("rand8 count", 64'(got), 64'(n_ops));
    check("rand8 leftover", 64'(exp_q8.size()), 64'd0);
  endtask

  task automatic rand32(input int n_ops);
    int issued = 0;
    int got    = 0;
    int cyc    = 0;
    logic [31:0] ra, rb;
    while (got < n_ops && cyc < 40000) begin
      bus32.out_ready = ($urandom_range(0, 3) != 0);
      if (bus32.in_ready && issued < n_ops) begin
        ra = $urandom;
        rb = $urandom;
        if (issued == 0) begin ra = 32'hffff_ffff; rb = 32'hffff_ffff; end
        if (issued == 1) rb = 32'd0;
        if (issued == 2) rb = 32'd1;
        bus32.a = ra;
        bus32.b = rb;
        bus32.in_valid = 1'b1;
        exp_q32.push_back(ref_product(ra, rb));
        issued++;
      end else begin
        bus32.in_valid = !bus32.in_ready && ($urandom_range(0, 1) == 1);
        bus32.a = $urandom;
        bus32.b = $urandom;
      end
      if (bus32.out_valid && bus32.out_ready) begin
        got++;
        if (exp_q32.size() == 0) check("rand32 spurious", 64'd1, 64'd0);
        else check("rand32 product", bus32.product, exp_q32.pop_front());
      end
      step();
      cyc++;
    end
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b0;
    check("rand32 count", 64'(got), 64'(n_ops));
    check("rand32 leftover", 64'(exp_q32.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int seen;
    rst = 1'b1;
    bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;  bus8.a = '0;  bus8.b = '0;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.a = '0; bus32.b = '0;
    step();
    step();
    check("reset state", 64'(dbg8), 64'(IDLE));
    check("reset in_ready", 64'(bus8.in_ready), 64'd1);
    check("reset out_valid", 64'(bus8.out_valid), 64'd0);
    check("reset product", 64'(bus8.product), 64'd0);
    check("reset product32", bus32.product, 64'd0);
    check("reset in_ready32", 64'(bus32.in_ready), 64'd1);
    rst = 1'b0;
    step();

    op8("13x11", 8'd13, 8'd11);   release8("13x11");
    op8("255x255", 8'd255, 8'd255); release8("255x255");
    op8("0x200", 8'd0, 8'd200);   release8("0x200");
    op8("200x0", 8'd200, 8'd0);   release8("200x0");

    // Back-pressure: product must hold and no new operand may enter.
    op8("hold", 8'd100, 8'd3);
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = 1'b1;
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      step();
      check("hold product", 64'(bus8.product), 64'd300);
      check("hold out_valid", 64'(bus8.out_valid), 64'd1);
      check("hold in_ready", 64'(bus8.in_ready), 64'd0);
    end
    // Handoff cycle with in_valid high: the new pair must not be taken yet.
    bus8.a = 8'd9;
    bus8.b = 8'd5;
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    check("handoff state", 64'(dbg8), 64'(IDLE));
    check("handoff out_valid", 64'(bus8.out_valid), 64'd0);
    op8("9x5 after handoff", 8'd9, 8'd5);
    release8("9x5");

    // Reset during the 4th CALC cycle, with in_valid high to test priority.
    bus8.a = 8'd100;
    bus8.b = 8'd100;
    bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    repeat (3) step();
    check("pre-reset calc", 64'(dbg8), 64'(CALC));
    rst = 1'b1;
    bus8.in_valid = 1'b1;
    step();
    rst = 1'b0;
    bus8.in_valid = 1'b0;
    check("mid reset state", 64'(dbg8), 64'(IDLE));
    check("mid reset product", 64'(bus8.product), 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus8.out_valid) seen++;
    end
    check("no out_valid after reset", 64'(seen), 64'd0);
    op8("7x6", 8'd7, 8'd6);       release8("7x6");

    op8("200x3", 8'd200, 8'd3);   release8("200x3");
    op8("77x1", 8'd77, 8'd1);     release8("77x1");
    op8("1x128", 8'd1, 8'd128);   release8("1x128");

    rand8(40);
    rand32(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
